// File: rtl/fm0_tx_encoder.sv
// fm0_tx_encoder: FM0 backscatter transmitter emitting optional pilot, preamble,
// handshaked data bits and a terminating dummy-1, with registered outputs.
module fm0_tx_encoder #(
    parameter int          HALF_CYCLES = 12,
    parameter logic [11:0] PREAMBLE_HS = 12'b110100100100
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic trext,
    input  logic data_in,
    input  logic data_last,
    input  logic data_valid,
    output logic data_ready,
    output logic mod_out,
    output logic busy,
    output logic done,
    output logic underrun
);
    typedef enum logic [2:0] {IDLE, PILOT, PREAMBLE, DATA, DUMMY} state_t;

    localparam logic [9:0] HC_MAX = 10'(HALF_CYCLES - 1);

    state_t     state_q, state_d;
    logic [9:0] hc_q, hc_d;
    logic [4:0] idx_q, idx_d, last_idx;
    logic       bit_q, bit_d, last_q, last_d;
    logic       mod_out_q, mod_out_d, busy_q, busy_d, done_q, done_d;
    logic       data_ready_q, data_ready_d, underrun_q, underrun_d;
    logic       hs_end, phase_end, xfer, new_lvl;

    // Outputs are registered from the next-cycle state so they line up with it.
    always_comb begin
        hs_end    = hc_q == HC_MAX;
        xfer      = data_ready_q & data_valid;
        last_idx  = state_q == PILOT ? 5'd23 : state_q == PREAMBLE ? 5'd11 : 5'd1;
        phase_end = (state_q != IDLE) & hs_end & (idx_q == last_idx);
        state_d   = state_q == IDLE ? (start ? (trext ? PILOT : PREAMBLE) : IDLE)
                  : !phase_end ? state_q
                  : state_q == PILOT ? PREAMBLE
                  : state_q == DUMMY ? IDLE
                  : xfer ? DATA : DUMMY;
        hc_d      = (state_q == IDLE || hs_end) ? 10'd0 : hc_q + 10'd1;
        idx_d     = (state_q == IDLE || phase_end) ? 5'd0 : idx_q + {4'd0, hs_end};
        bit_d     = xfer ? data_in : bit_q;
        last_d    = xfer ? data_last : last_q;
        // Data/dummy: first half inverts; second half holds only for a 1.
        new_lvl   = state_d == PILOT ? ~idx_d[0]
                  : state_d == PREAMBLE ? PREAMBLE_HS[4'd11 - idx_d[3:0]]
                  : (idx_d[0] & (bit_q | state_d == DUMMY)) ? mod_out_q : ~mod_out_q;
        mod_out_d = state_d == IDLE ? 1'b0 : hc_d == 10'd0 ? new_lvl : mod_out_q;
        busy_d    = state_d != IDLE;
        done_d    = phase_end & (state_q == DUMMY);
        underrun_d = data_ready_q & ~data_valid;
        data_ready_d = (hc_d == HC_MAX)
                     & (((state_d == PREAMBLE) & (idx_d == 5'd11))
                      | ((state_d == DATA) & (idx_d == 5'd1) & ~last_d));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            hc_q         <= '0;
            idx_q        <= '0;
            bit_q        <= 1'b0;
            last_q       <= 1'b0;
            mod_out_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            data_ready_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            hc_q         <= hc_d;
            idx_q        <= idx_d;
            bit_q        <= bit_d;
            last_q       <= last_d;
            mod_out_q    <= mod_out_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            data_ready_q <= data_ready_d;
            underrun_q   <= underrun_d;
        end
    end

    assign mod_out    = mod_out_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign data_ready = data_ready_q;
    assign underrun   = underrun_q;
endmodule

// File: tb/tb_fm0_tx_encoder.sv
// tb_fm0_tx_encoder: frame table drives two encoders (H=4, H=2); a frame-level
// waveform model fills a per-cycle scoreboard that is checked on falling edges.
module tb_fm0_tx_encoder;
    logic clk = 0, reset = 0, start = 0, trext = 0, sel = 0;
    logic data_in = 0, data_last = 0, data_valid = 0;
    logic ready_a, mod_a, busy_a, done_a, und_a;
    logic ready_b, mod_b, busy_b, done_b, und_b;
    logic [4:0] outs;

    always #5 clk = ~clk;

    fm0_tx_encoder #(.HALF_CYCLES(4)) dut_a (
        .clk(clk), .reset(reset), .start(start & ~sel), .trext(trext),
        .data_in(data_in), .data_last(data_last), .data_valid(data_valid),
        .data_ready(ready_a), .mod_out(mod_a), .busy(busy_a), .done(done_a), .underrun(und_a));

    fm0_tx_encoder #(.HALF_CYCLES(2)) dut_b (
        .clk(clk), .reset(reset), .start(start & sel), .trext(trext),
        .data_in(data_in), .data_last(data_last), .data_valid(data_valid),
        .data_ready(ready_b), .mod_out(mod_b), .busy(busy_b), .done(done_b), .underrun(und_b));

    // Packed as {mod_out, busy, done, data_ready, underrun}
    assign outs = sel ? {mod_b, busy_b, done_b, ready_b, und_b} : {mod_a, busy_a, done_a, ready_a, und_a};

    typedef struct {
        int          h;
        logic        tx;
        int          n;
        logic [15:0] bits;
        int          uf;
        int          stray;
        logic        chain;
        int          exp_busy;
        int          exp_done;
    } row_t;

    row_t       tbl[8];
    logic [4:0] sb[$];
    int         n_cmp = 0, n_bad = 0;

    task automatic chk(input string nm, input logic [4:0] act, input logic [4:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s got %b exp %b (mod,busy,done,ready,und)", nm, act, exp);
        end
    endtask

    task automatic chk_i(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s got %0d exp %0d", nm, act, exp);
        end
    endtask

    task automatic drive_data(input row_t r, input int ptr);
        data_in    = ptr < 16 ? r.bits[ptr] : 1'b0;
        data_last  = ptr == r.n - 1;
        data_valid = ptr < r.n && ptr != r.uf;
    endtask

    task automatic run_frame(input int id, input row_t r);
        logic        hs [0:79];
        logic [11:0] pre = 12'b110100100100;
        logic        lvl, a, xf;
        logic [4:0]  e, o;
        int nhs = 0, p, ns, last_rdy, len, ncyc, ptr = 0, busy_cnt = 0, done_at = -1;
        p = r.tx ? 24 : 0;
        for (int i = 0; i < p; i++) begin hs[nhs] = (i % 2 == 0); nhs++; end
        for (int i = 0; i < 12; i++) begin hs[nhs] = pre[11 - i]; nhs++; end
        lvl = hs[nhs - 1];
        ns = r.uf >= 0 ? r.uf : r.n;
        for (int k = 0; k < ns; k++) begin
            a = ~lvl;
            lvl = r.bits[k] ? a : ~a;
            hs[nhs] = a; hs[nhs + 1] = lvl; nhs += 2;
        end
        hs[nhs] = ~lvl; hs[nhs + 1] = ~lvl; nhs += 2;
        len = nhs * r.h;
        last_rdy = r.uf >= 0 ? r.uf : r.n - 1;
        ncyc = r.chain ? len + 1 : len + 2;
        for (int c = 1; c <= ncyc; c++) begin
            e = '0;
            e[4] = c <= len ? hs[(c - 1) / r.h] : 1'b0;
            e[3] = c <= len;
            e[2] = c == len + 1;
            for (int k = 0; k <= last_rdy; k++) if (c == (p + 12 + 2 * k) * r.h) e[1] = 1'b1;
            e[0] = r.uf >= 0 && c == (p + 12 + 2 * r.uf) * r.h + 1;
            sb.push_back(e);
        end
        sel = r.h == 2;
        start = 1; trext = r.tx;
        drive_data(r, ptr);
        @(posedge clk); #1;
        start = 0; trext = 0;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            o = outs;
            chk($sformatf("row%0d cyc%0d", id, c), o, sb.pop_front());
            if (o[3]) busy_cnt++;
            if (o[2] && done_at < 0) done_at = c;
            xf = o[1] && data_valid;
            if (c == ncyc) break;
            @(posedge clk); #1;
            if (xf) ptr++;
            drive_data(r, ptr);
            start = (c + 1 == r.stray) || (r.chain && c + 1 == len + 1);
            trext = c + 1 == r.stray ? 1'b1 : r.tx;
        end
        chk_i($sformatf("row%0d busy_len", id), busy_cnt, r.exp_busy);
        chk_i($sformatf("row%0d done_at", id), done_at, r.exp_done);
    endtask

    initial begin
        //            h  tx  n  bits      uf  stray chain busy done
        tbl[0] = '{4, 0, 2, 16'h0001, -1, 30, 1, 72, 73};
        tbl[1] = '{4, 0, 2, 16'h0001, -1, 0, 0, 72, 73};
        tbl[2] = '{4, 1, 2, 16'h0001, -1, 0, 0, 168, 169};
        tbl[3] = '{4, 0, 2, 16'h0001, 0, 0, 0, 56, 57};
        tbl[4] = '{4, 0, 5, 16'h000D, -1, 0, 0, 96, 97};
        tbl[5] = '{4, 1, 3, 16'h0000, 1, 0, 0, 160, 161};
        tbl[6] = '{2, 0, 8, 16'h0055, -1, 0, 0, 60, 61};
        tbl[7] = '{2, 1, 1, 16'h0001, -1, 0, 0, 80, 81};
        #1 reset = 1;
        repeat (3) @(negedge clk);
        sel = 0; #1 chk("reset_a", outs, 5'b0);
        sel = 1; #1 chk("reset_b", outs, 5'b0);
        @(negedge clk) reset = 0;
        sel = 0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 8; i++) run_frame(i, tbl[i]);
        // Asynchronous reset in the middle of a preamble
        sel = 0; data_valid = 1; data_in = 0; data_last = 1;
        start = 1;
        @(posedge clk); #1 start = 0;
        repeat (19) @(posedge clk);
        #1 chk_i("busy_before_reset", int'(busy_a), 1);
        #1 reset = 1;
        #1 chk("reset_mid_frame", outs, 5'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("reset_hold%0d", i), outs, 5'b0);
        end
        reset = 0;
        @(negedge clk);
        run_frame(8, tbl[4]);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
